// File: rtl/gpio_in_event_ctrl.sv
// gpio_in_event_ctrl: resynchronises filtered pad inputs and detects per-pin
// edge/level events. The events feed sticky W1C status bits and one masked
// interrupt.
// Optional feature macro: GPIO_EVT_CNT_EN adds per-pin saturating event counters.
module gpio_in_event_ctrl #(
  parameter int unsigned NUM_PINS    = 4,
  parameter int unsigned SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_PINS-1:0]   i_pad_in,
  input  logic [3*NUM_PINS-1:0] i_evt_mode,
  input  logic [NUM_PINS-1:0]   i_irq_en,
  input  logic [NUM_PINS-1:0]   i_clr,
`ifdef GPIO_EVT_CNT_EN
  input  logic [NUM_PINS-1:0]   i_cnt_clr,
  output logic [8*NUM_PINS-1:0] o_evt_cnt,
`endif
  output logic [NUM_PINS-1:0]   o_sync_in,
  output logic [NUM_PINS-1:0]   o_evt_pulse,
  output logic [NUM_PINS-1:0]   o_evt_status,
  output logic                  o_irq
);

  localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

  localparam logic [2:0] MODE_OFF  = 3'b000;
  localparam logic [2:0] MODE_RISE = 3'b001;
  localparam logic [2:0] MODE_FALL = 3'b010;
  localparam logic [2:0] MODE_BOTH = 3'b011;
  localparam logic [2:0] MODE_HIGH = 3'b100;
  localparam logic [2:0] MODE_LOW  = 3'b101;

  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
  logic [NUM_PINS-1:0]                  prev_q, prev_d;
  logic [NUM_PINS-1:0]                  pulse_q, pulse_d;
  logic [NUM_PINS-1:0]                  status_q, status_d;
  logic                                 irq_q, irq_d;
  logic [ARM_W-1:0]                     arm_q, arm_d;
  logic                                 armed_c;
  logic [NUM_PINS-1:0]                  sync_last_c;
  logic [NUM_PINS-1:0]                  hit_c;

  assign sync_last_c = sync_q[SYNC_STAGES-1];
  assign armed_c     = (arm_q == ARM_W'(ARM_MAX));

  // Synchroniser shift chain and one-cycle-delayed copy of its output
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = i_pad_in;
    for (int s = 1; s < int'(SYNC_STAGES); s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = sync_last_c;
  end

  // Arm counter: holds off events until the synchroniser has filled after reset
  always_comb begin
    arm_d = arm_q;
    if (!armed_c) begin
      arm_d = arm_q + ARM_W'(1);
    end
  end

  // Per-pin mode decode of sync/prev; reserved modes behave as disabled
  always_comb begin
    hit_c = '0;
    for (int n = 0; n < int'(NUM_PINS); n++) begin
      case (i_evt_mode[3*n +: 3])
        MODE_OFF:  hit_c[n] = 1'b0;
        MODE_RISE: hit_c[n] = sync_last_c[n] & ~prev_q[n];
        MODE_FALL: hit_c[n] = ~sync_last_c[n] & prev_q[n];
        MODE_BOTH: hit_c[n] = sync_last_c[n] ^ prev_q[n];
        MODE_HIGH: hit_c[n] = sync_last_c[n];
        MODE_LOW:  hit_c[n] = ~sync_last_c[n];
        default:   hit_c[n] = 1'b0;
      endcase
    end
    if (!armed_c) begin
      hit_c = '0;
    end
  end

  // Event strobe, sticky status (set beats clear) and masked interrupt
  always_comb begin
    pulse_d  = hit_c;
    status_d = hit_c | (status_q & ~i_clr);
    irq_d    = |(status_q & i_irq_en);
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q   <= '0;
      prev_q   <= '0;
      pulse_q  <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
      arm_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      pulse_q  <= pulse_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      arm_q    <= arm_d;
    end
  end

  assign o_sync_in    = sync_last_c;
  assign o_evt_pulse  = pulse_q;
  assign o_evt_status = status_q;
  assign o_irq        = irq_q;

`ifdef GPIO_EVT_CNT_EN
  logic [NUM_PINS-1:0][7:0] cnt_q, cnt_d;

  // Saturating per-pin event counters; a clear that coincides with a pulse leaves 1
  always_comb begin
    cnt_d = cnt_q;
    for (int n = 0; n < int'(NUM_PINS); n++) begin
      if (i_cnt_clr[n]) begin
        cnt_d[n] = pulse_q[n] ? 8'd1 : 8'd0;
      end else if (pulse_q[n] && (cnt_q[n] != 8'hFF)) begin
        cnt_d[n] = cnt_q[n] + 8'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_evt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gpio_in_event_ctrl.sv
// Directed self-checking bench for gpio_in_event_ctrl (NUM_PINS=4, SYNC_STAGES=2).
module tb_gpio_in_event_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  pad_in;
  logic [11:0] evt_mode;
  logic [3:0]  irq_en;
  logic [3:0]  clr;
  logic [3:0]  sync_in;
  logic [3:0]  evt_pulse;
  logic [3:0]  evt_status;
  logic        irq;
`ifdef GPIO_EVT_CNT_EN
  logic [3:0]  cnt_clr;
  logic [31:0] evt_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int npulse;

  gpio_in_event_ctrl #(.NUM_PINS(4), .SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pad_in     (pad_in),
    .i_evt_mode   (evt_mode),
    .i_irq_en     (irq_en),
    .i_clr        (clr),
`ifdef GPIO_EVT_CNT_EN
    .i_cnt_clr    (cnt_clr),
    .o_evt_cnt    (evt_cnt),
`endif
    .o_sync_in    (sync_in),
    .o_evt_pulse  (evt_pulse),
    .o_evt_status (evt_status),
    .o_irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle 1ns past it
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    pad_in   = 4'b1111;
    evt_mode = 12'h249;          // all pins rising
    irq_en   = 4'b0000;
    clr      = 4'b0000;
`ifdef GPIO_EVT_CNT_EN
    cnt_clr  = 4'b0000;
`endif
    tick(3);
    check("rst_sync",   32'(sync_in), 0);
    check("rst_pulse",  32'(evt_pulse), 0);
    check("rst_status", 32'(evt_status), 0);
    check("rst_irq",    32'(irq), 0);

    // Reset release with pads high: sync fills, no false rising edge
    rst_n = 1'b1;
    tick(2);
    check("fill_sync", 32'(sync_in), 32'hF);
    for (int i = 0; i < 5; i++) begin
      check("fill_pulse", 32'(evt_pulse), 0);
      tick();
    end
    check("fill_status", 32'(evt_status), 0);
    check("fill_irq",    32'(irq), 0);

    // Pin0 rising: latency 3 edges, single-cycle pulse, irq one cycle after status
    evt_mode = 12'h001;
    pad_in   = 4'b1110;
    tick(4);
    check("p0_fall_ignored", 32'(evt_status), 0);
    irq_en = 4'b0001;
    pad_in = 4'b1111;
    tick(2);
    check("p0_sync", 32'(sync_in), 32'hF);
    check("p0_pulse_early", 32'(evt_pulse), 0);
    tick();
    check("p0_pulse",   32'(evt_pulse), 32'h1);
    check("p0_status",  32'(evt_status), 32'h1);
    check("p0_irq_lag", 32'(irq), 0);
    tick();
    check("p0_pulse_end", 32'(evt_pulse), 0);
    check("p0_irq",       32'(irq), 1);
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    check("p0_clr",      32'(evt_status), 0);
    check("p0_irq_hold", 32'(irq), 1);
    tick();
    check("p0_irq_fall", 32'(irq), 0);

    // Pin1 both edges: 0->1->0 with 10-cycle spacing gives two pulses
    pad_in = 4'b1101;
    tick(4);
    evt_mode = 12'h018;
    irq_en   = 4'b0010;
    tick(2);
    check("p1_mode_change_no_evt", 32'(evt_status), 0);
    pad_in = 4'b1111;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (evt_pulse[1]) npulse++;
    end
    check("p1_rise_pulses", 32'(npulse), 1);
    pad_in = 4'b1101;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (evt_pulse[1]) npulse++;
    end
    check("p1_fall_pulses", 32'(npulse), 1);
    check("p1_status", 32'(evt_status), 32'h2);
    check("p1_irq",    32'(irq), 1);
    clr = 4'b0010;
    tick();
    clr = 4'b0000;
    check("p1_clr",      32'(evt_status), 0);
    check("p1_irq_hold", 32'(irq), 1);
    tick();
    check("p1_irq_fall", 32'(irq), 0);

    // Pin2 level low: pulse every cycle, clear cannot drop status while level holds
    evt_mode = 12'h140;
    pad_in   = 4'b1001;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      check("p2_level_pulse", 32'(evt_pulse), 32'h4);
      tick();
    end
    clr = 4'b0100;
    tick();
    clr = 4'b0000;
    check("p2_clr_level", 32'(evt_status), 32'h4);
    pad_in = 4'b1101;
    tick(4);
    check("p2_level_gone", 32'(evt_pulse), 0);
    check("p2_status_kept", 32'(evt_status), 32'h4);
    clr = 4'b0100;
    tick();
    clr = 4'b0000;
    check("p2_clr", 32'(evt_status), 0);

    // Pin3 falling edge coinciding with clear: set wins
    evt_mode = 12'h400;
    pad_in   = 4'b0101;
    tick(2);
    clr = 4'b1000;
    tick();
    clr = 4'b0000;
    check("p3_pulse",        32'(evt_pulse), 32'h8);
    check("p3_set_over_clr", 32'(evt_status), 32'h8);

    // Mode change alone: no event, status retained; masking drops irq
    irq_en   = 4'b1000;
    tick(2);
    check("p3_irq", 32'(irq), 1);
    evt_mode = 12'h600;          // pin3 both edges, pad steady
    irq_en   = 4'b0000;
    tick();
    check("mask_irq", 32'(irq), 0);
    tick(2);
    check("mode_chg_pulse",  32'(evt_pulse), 0);
    check("mode_chg_status", 32'(evt_status), 32'h8);

    // Reserved mode on pin0 ignores toggles
    evt_mode = 12'h006;
    pad_in   = 4'b0100;
    tick(4);
    pad_in   = 4'b0101;
    tick(4);
    check("reserved_mode", 32'(evt_status), 32'h8);

    // Reset mid-operation: state cleared, arm delay applies again
    rst_n = 1'b0;
    #2;
    check("midrst_status", 32'(evt_status), 0);
    check("midrst_sync",   32'(sync_in), 0);
    evt_mode = 12'h249;
    pad_in   = 4'b1111;
    tick();
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (evt_pulse != 4'b0000) npulse++;
    end
    check("midrst_no_evt", 32'(npulse), 0);
    check("midrst_status_after", 32'(evt_status), 0);

`ifdef GPIO_EVT_CNT_EN
    // 300 rising edges on pin0 saturate its counter at 255
    evt_mode = 12'h001;
    for (int i = 0; i < 300; i++) begin
      pad_in = 4'b1110;
      tick();
      pad_in = 4'b1111;
      tick();
    end
    tick(4);
    check("cnt_sat", evt_cnt & 32'hFF, 255);
    check("cnt_other", evt_cnt & 32'hFFFF_FF00, 0);
    cnt_clr = 4'b0001;
    tick();
    cnt_clr = 4'b0000;
    check("cnt_clr", evt_cnt & 32'hFF, 0);
    pad_in = 4'b1110;
    tick(4);
    pad_in = 4'b1111;
    tick(3);
    check("cnt_pulse_now", 32'(evt_pulse), 32'h1);
    cnt_clr = 4'b0001;
    tick();
    cnt_clr = 4'b0000;
    check("cnt_clr_with_evt", evt_cnt & 32'hFF, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
